// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0) injected into IF/ID during stolen cycles
    localparam logic [31:0] NOP_INST = 32'h00000013;

    // FETCH owns the port; DATA_DONE is the fetch cycle that follows a stolen one
    typedef enum logic {
        ST_FETCH     = 1'b0,
        ST_DATA_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline, the arbiter and the single-ported memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic [ADDR_W-1:0] if_addr;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] ls_rdata;
    logic              pipe_load;
    logic [CNT_W-1:0]  stall_cnt;

    // Arbiter side
    modport slave (
        input  if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output mem_addr, mem_we, mem_wdata, inst, ls_rdata, pipe_load, stall_cnt
    );

    // Pipeline/memory side
    modport master (
        output if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, inst, ls_rdata, pipe_load, stall_cnt
    );
endinterface

// File: rtl/mem_port_arbiter_register.sv
// Generic N-bit load-enabled register with asynchronous active-high clear.
module Register #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Capture d when load is set; clear immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified instruction/data memory port: fetch by default,
// a load/store steals exactly one cycle while the whole pipeline is frozen.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INST);

    state_t           state_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic             data_cycle;
    logic             rdata_load;
    logic             rdata_clr;

    // A request is served only from FETCH; in DATA_DONE ls_req still shows the served op
    assign data_cycle = reset && (state_q == ST_FETCH) && bus.ls_req;
    assign rdata_load = data_cycle && !bus.ls_we;
    assign rdata_clr  = ~reset;

    // Port steering and pipeline freeze, forced safe while reset is asserted
    assign bus.mem_addr  = data_cycle ? bus.ls_addr : bus.if_addr;
    assign bus.mem_we    = data_cycle && bus.ls_we;
    assign bus.mem_wdata = bus.ls_wdata;
    assign bus.inst      = (reset && !data_cycle) ? bus.mem_rdata : NOP_W;
    assign bus.pipe_load = reset && !data_cycle;
    assign bus.ls_rdata  = rdata_q;
    assign bus.stall_cnt = stall_cnt_q;

    // Two-state sequencer with saturating stolen-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.ls_req) begin
                        state_q <= ST_DATA_DONE;
                        if (stall_cnt_q != '1) begin
                            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DATA_DONE: begin
                    state_q <= ST_FETCH;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    Register #(
        .N(DATA_W)
    ) u_ls_rdata (
        .clk  (clk),
        .reset(rdata_clr),
        .load (rdata_load),
        .d    (bus.mem_rdata),
        .q    (rdata_q)
    );

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single-ported unified instruction/data memory between instruction fetch and the MEM-stage load/store. Fetch owns the port by default. A load/store steals the port for one cycle, and the block freezes every pipeline register during that cycle. It sits between the PC/EX-MEM stage registers and the memory, and it drives the shared `load` enable of the PC and all stage registers.

## Interface
- `ADDR_W`, default 32, memory address width
- `DATA_W`, default 32, memory word width
- `CNT_W`, default 16, stall counter width
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low (0 = reset asserted)
- `if_addr` in ADDR_W: fetch address (PC)
- `ls_req` in 1: EX/MEM holds a load or store (MemRead|MemWrite)
- `ls_we` in 1: 1 = store, 0 = load
- `ls_addr` in ADDR_W: load/store address
- `ls_wdata` in DATA_W: store data
- `mem_addr` out ADDR_W: memory address
- `mem_we` out 1: memory write enable (memory writes on posedge)
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: combinational memory read data
- `inst` out DATA_W: fetched instruction to IF/ID
- `ls_rdata` out DATA_W: held load data to MEM/WB
- `pipe_load` out 1: load enable for PC and all stage registers
- `stall_cnt` out CNT_W: count of stolen cycles

## Operation
- Two-state FSM: FETCH (reset state) and DATA_DONE.
- **FETCH, ls_req=0:**
  - mem_addr=if_addr, mem_we=0, inst=mem_rdata, pipe_load=1.
  - Stay in FETCH.
- **FETCH, ls_req=1 (data cycle):**
  - mem_addr=ls_addr, mem_we=ls_we, mem_wdata=ls_wdata.
  - inst=NOP (32'h00000013), pipe_load=0.
  - On the clock edge, ls_rdata captures mem_rdata if ls_we=0 and holds otherwise; stall_cnt increments.
  - Next state DATA_DONE.
- **DATA_DONE:**
  - Behaves as a FETCH cycle: mem_addr=if_addr, mem_we=0, inst=mem_rdata, pipe_load=1.
  - ls_req is ignored, because it still reflects the operation already served. The store must not repeat.
  - Next state FETCH.
- **Back-to-back loads/stores:** each costs exactly one stolen cycle, giving the pattern DATA, DONE, DATA, DONE.
- **stall_cnt:** saturates at all-ones and does not wrap.
- **ls_rdata:** changes only on the edge that ends a load data cycle. It is stable through DATA_DONE and later cycles.
- **mem_wdata:** equals ls_wdata in all states. It is qualified only by mem_we.

## Timing
- **Reset values:**
  - state=FETCH, ls_rdata=0, stall_cnt=0.
  - While reset=0, combinational outputs are forced: mem_we=0, pipe_load=0, inst=NOP. mem_addr=if_addr.
- **Reset mid-operation:** asserting reset during a data cycle aborts it. No write reaches memory because mem_we is forced to 0. The FSM returns to FETCH; ls_rdata and stall_cnt clear immediately.
- **Reset release:** the first cycle with reset=1 is a FETCH cycle. If ls_req is already 1 in that cycle, it is a data cycle.
- **Latency:**
  - Instruction: combinational, available in the same cycle.
  - Load data: valid in ls_rdata from the edge ending the data cycle.
  - Store: committed on that same edge.
- **Outputs:** mem_addr, mem_we, inst and pipe_load are combinational from state, ls_req and reset. They are glitch-tolerant because memory and registers sample on posedge.

## Structure
- Shared constants in the common header/package:
  - NOP_INST = 32'h00000013
  - state encodings ST_FETCH=1'b0, ST_DATA_DONE=1'b1
- Sub-module: one instance of the existing `Register` (N=DATA_W) for ls_rdata.
  - load = data cycle & ~ls_we
  - reset = ~reset
- FSM and saturating counter are inline.
- Target size: about 150 lines.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with ls_req=1 -> mem_we=0, pipe_load=0, inst=0x00000013, stall_cnt=0; the first cycle after release is a data cycle.
- **Pure fetch:** ls_req=0, if_addr=0x10, mem_rdata=0x00500093 -> inst=0x00500093, pipe_load=1 every cycle, stall_cnt stays 0.
- **Load:** ls_req=1, ls_we=0, ls_addr=0x200, mem_rdata=0xDEADBEEF in the data cycle -> pipe_load=0 for one cycle, ls_rdata=0xDEADBEEF from the next edge, FSM in DATA_DONE with pipe_load=1, stall_cnt=1.
- **Store:** ls_req=1, ls_we=1, ls_addr=0x204, ls_wdata=0x12345678 held for 2 cycles -> mem_we=1 for exactly one cycle at 0x204; ls_rdata unchanged.
- **Back-to-back and reset mid-op:**
  - 4 consecutive load instructions -> pipe_load pattern 0,1,0,1,0,1,0,1 and stall_cnt=4.
  - Asserting reset during the data cycle of a store -> no write, state FETCH, counters cleared.
- **Saturation:** with CNT_W=2, run 5 loads -> stall_cnt goes 1,2,3,3,3.
